// File: rtl/vga_text_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_pkg
// Description : Shared constants for the 80x30 text-mode pixel generator.
//               Covers screen geometry, glyph size, attribute word layout
//               and the 16-colour CGA palette in 12-bit RGB.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_text_pkg;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    // Attribute word layout: {bg[3:0], fg[3:0], char[7:0]}
    localparam int ATTR_CHAR_LSB = 0;
    localparam int ATTR_CHAR_MSB = 7;
    localparam int ATTR_FG_LSB   = 8;
    localparam int ATTR_FG_MSB   = 11;
    localparam int ATTR_BG_LSB   = 12;
    localparam int ATTR_BG_MSB   = 15;

    // Packed so that CGA_PALETTE[i] is colour index i (entry 0 is rightmost).
    localparam logic [15:0][11:0] CGA_PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
        return CGA_PALETTE[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_gen_blink_ctr.sv
`default_nettype none
// ============================================================================
// Module      : vga_blink_ctr
// Description : Cursor blink timebase. Counts rising edges of the raw vsync
//               input (sampled on pixel ticks) and toggles blink_phase every
//               BLINK_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_blink_ctr #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic p_tick,
    input  logic vsync,
    output logic blink_phase
);

    // A single-frame period would need a zero-width counter; keep one bit.
    localparam int               CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             r_vsync_prev;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_blink_phase;
    logic             w_vs_rise;

    assign w_vs_rise   = p_tick & vsync & ~r_vsync_prev;
    assign blink_phase = r_blink_phase;

    // Edge-detect vsync on pixel ticks, count frames, toggle phase on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_prev  <= 1'b0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (p_tick) begin
            r_vsync_prev <= vsync;
            if (w_vs_rise) begin
                if (r_frame_cnt == C_LAST) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_text_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_gen
// Description : 80x30 text-mode pixel generator with 8x16 glyphs. Fetches
//               char/attribute from an external synchronous text RAM, glyph
//               rows from an external synchronous font ROM, overlays a
//               blinking underline cursor and realigns syncs to the 3-tick
//               fetch pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_gen
    import vga_text_pkg::*;
#(
    parameter int COLS_P       = COLS,
    parameter int ROWS_P       = ROWS,
    parameter int BLINK_FRAMES = 30,
    // Pixel-tick latency of the rgb path; the stage structure fixes it at 3.
    parameter int PIPE         = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] pixel_x,
    input  logic [11:0] pixel_y,
    output logic [11:0] text_addr,
    input  logic [15:0] text_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    // ------------------------------------------------------------------
    // Stage-1 combinational decode
    // ------------------------------------------------------------------
    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic [11:0] w_addr;
    logic        w_cur_hit;
    logic        w_unused;

    assign w_col = pixel_x[9:3];
    assign w_row = pixel_y[8:4];

    // row*80 + col as (row<<6) + (row<<4) + col, wrapping at 12 bits.
    assign w_addr = {1'b0, w_row, 6'b0} + {3'b0, w_row, 4'b0} + {5'b0, w_col};

    // Out-of-range cursor coordinates are rejected so they never alias
    // onto the off-screen columns/rows produced during blanking.
    assign w_cur_hit = cursor_en
                     & (w_col == cursor_col) & (w_row == cursor_row)
                     & (cursor_col < 7'(COLS_P)) & (cursor_row < 5'(ROWS_P));

    assign w_unused = ^{pixel_x[11:10], pixel_y[11:9]};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [11:0] r_text_addr;
    logic [2:0]  r_x1;
    logic [3:0]  r_y1;
    logic        r_von1;
    logic        r_hit1;

    logic [11:0] r_font_addr;
    logic [3:0]  r_fg2;
    logic [3:0]  r_bg2;
    logic [2:0]  r_x2;
    logic [3:0]  r_y2;
    logic        r_von2;
    logic        r_hit2;

    logic        r_pix3;
    logic [3:0]  r_fg3;
    logic [3:0]  r_bg3;
    logic        r_von3;

    logic [11:0] r_rgb;

    // Syncs are a plain PIPE+1 deep shift of {hsync, vsync}: the first
    // entry lines up with stage 1, the last one is the output register.
    logic [PIPE:0][1:0] r_sync_dly;

    // ------------------------------------------------------------------
    // Stage-3 combinational pixel select and cursor overlay
    // ------------------------------------------------------------------
    logic       w_blink_phase;
    logic [2:0] w_bit_idx;
    logic       w_cursor_on;
    logic       w_pix;

    assign w_bit_idx   = 3'(GLYPH_W - 1) - r_x2;
    assign w_cursor_on = r_hit2 & w_blink_phase & (r_y2 >= 4'(GLYPH_H - 2));
    assign w_pix       = font_data[w_bit_idx] | w_cursor_on;

    // Advance the whole fetch/render pipeline on each pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_text_addr <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_von1      <= 1'b0;
            r_hit1      <= 1'b0;
            r_font_addr <= '0;
            r_fg2       <= '0;
            r_bg2       <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_von2      <= 1'b0;
            r_hit2      <= 1'b0;
            r_pix3      <= 1'b0;
            r_fg3       <= '0;
            r_bg3       <= '0;
            r_von3      <= 1'b0;
            r_rgb       <= '0;
            r_sync_dly  <= '0;
        end else if (p_tick) begin
            // Stage 1: issue text RAM read, capture position and cursor hit
            r_text_addr <= w_addr;
            r_x1        <= pixel_x[2:0];
            r_y1        <= pixel_y[3:0];
            r_von1      <= video_on;
            r_hit1      <= w_cur_hit;
            // Stage 2: text word is back, issue font ROM read
            r_font_addr <= {text_data[ATTR_CHAR_MSB:ATTR_CHAR_LSB], r_y1};
            r_fg2       <= text_data[ATTR_FG_MSB:ATTR_FG_LSB];
            r_bg2       <= text_data[ATTR_BG_MSB:ATTR_BG_LSB];
            r_x2        <= r_x1;
            r_y2        <= r_y1;
            r_von2      <= r_von1;
            r_hit2      <= r_hit1;
            // Stage 3: glyph row is back, pick the pixel bit
            r_pix3      <= w_pix;
            r_fg3       <= r_fg2;
            r_bg3       <= r_bg2;
            r_von3      <= r_von2;
            // Output: colour lookup with blanking
            r_rgb       <= r_von3 ? palette_lookup(r_pix3 ? r_fg3 : r_bg3) : 12'h000;
            r_sync_dly  <= {r_sync_dly[PIPE-1:0], {hsync, vsync}};
        end
    end

    vga_blink_ctr #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (p_tick),
        .vsync       (vsync),
        .blink_phase (w_blink_phase)
    );

    assign text_addr = r_text_addr;
    assign font_addr = r_font_addr;
    assign rgb       = r_rgb;
    assign hsync_out = r_sync_dly[PIPE][1];
    assign vsync_out = r_sync_dly[PIPE][0];

endmodule
`default_nettype wire

// File: doc/vga_text_gen.md
Name: vga_text_gen

Overview:
- Pixel generator directly downstream of the VGA sync/timing stage.
- Consumes pixel_x/pixel_y/video_on/hsync/vsync/p_tick and renders an 80x30 text screen using 8x16 glyphs.
- Reads character codes and attributes from a synchronous text RAM and glyph rows from a synchronous font ROM, both external to this block.
- Delays syncs and blanking to match the fetch pipeline, and overlays a blinking underline cursor.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- BLINK_FRAMES, 30, frames per cursor blink half-period
- PIPE, 3, pixel-tick latency from timing inputs to rgb/sync outputs (fixed; documented only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel enable from the timing stage (one clk in two)
- video_on  in  1  display-area flag from the timing stage
- hsync  in  1  horizontal sync from the timing stage (polarity passed through)
- vsync  in  1  vertical sync from the timing stage (polarity passed through)
- pixel_x  in  12  current column, 0..799
- pixel_y  in  12  current line, 0..524
- text_addr  out  12  text RAM read address = row*COLS+col
- text_data  in  16  [7:0] char code, [11:8] fg index, [15:12] bg index; valid 1 clk after text_addr
- font_addr  out  12  font ROM address = {code[7:0], glyph_row[3:0]}
- font_data  in  8  glyph row; bit 7 = leftmost pixel; valid 1 clk after font_addr
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column, 0..79
- cursor_row  in  5  cursor row, 0..29
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- hsync_out  out  1  hsync delayed by PIPE ticks
- vsync_out  out  1  vsync delayed by PIPE ticks

Behaviour:
- Reset: every output and register is 0, including text_addr, font_addr, rgb, hsync_out, vsync_out, the blink counter and the blink phase. Reset asserted mid-frame clears everything on the same edge. After release, outputs are valid PIPE ticks later.
- Pipeline advance: all pipeline registers advance only on clk edges where p_tick=1. With p_tick=0 every register holds. Each RAM/ROM therefore has 2 clk to respond.
- Stage 1 (tick k):
  - col = pixel_x[9:3], row = pixel_y[8:4].
  - text_addr <= row*80+col.
  - Computed with shift-add: (row<<6)+(row<<4)+col, 12-bit, no overflow for row<=29.
  - Outside the display area the address is don't-care, but it must stay 12-bit wrapped.
  - Register x[2:0], y[3:0], video_on, hsync, vsync, and cur_hit = cursor_en & col==cursor_col & row==cursor_row.
- Stage 2 (tick k+1):
  - Capture text_data.
  - font_addr <= {text_data[7:0], y_d1[3:0]}.
  - Register fg/bg indices and forward the delayed stage-1 fields.
- Stage 3 (tick k+2):
  - Capture font_data.
  - pix = font_data[7 - x_d2[2:0]].
  - Cursor overlay: if cur_hit_d2 & blink_phase & y_d2[3:0]>=14, then pix = 1.
- Output (tick k+3):
  - rgb <= video_on_d3 ? PALETTE[pix ? fg : bg] : 12'h000.
  - hsync_out and vsync_out are the inputs delayed by exactly 3 ticks.
  - Outputs are therefore exactly 3 ticks (6 clk) behind the inputs.
- Blink:
  - Detect the vsync rising edge on the un-delayed input, sampled on p_tick.
  - frame counter 0..BLINK_FRAMES-1; on wrap to 0, toggle blink_phase.
  - A vsync edge and reset together: reset wins.
- Boundaries:
  - x 640..799 or y 480..524: rgb=0 regardless of memory data.
  - col 79 / row 29 give text_addr 2399 max.
  - Cursor coordinates out of range (col>79, row>29) never hit.
  - cursor inputs are sampled in stage 1 only; changes mid-character take effect at the next stage-1 sample.

Decomposition:
- Package vga_text_pkg holds:
  - COLS, ROWS, GLYPH_W=8, GLYPH_H=16
  - the 16-entry CGA palette as 12-bit constants (0:000, 1:00A, 2:0A0, 3:0AA, 4:A00, 5:A0A, 6:A50, 7:AAA, 8:555, 9:55F, A:5F5, B:5FF, C:F55, D:F5F, E:FF5, F:FFF)
  - the attribute field bit positions
- One sub-module, vga_blink_ctr: vsync edge detect, frame counter and blink_phase.

Test Plan:
- Reset held 10 clk, then released with timing inputs idle → rgb=000, hsync_out=vsync_out=0 throughout; first valid rgb appears 6 clk after the first p_tick.
- Pixel (x=8, y=16) → text_addr=81. Memory model returns 16'h1F41 ('A', fg=F, bg=1) then font 8'h80. At x=8 → rgb=FFF; x=9 → rgb=00A, both 3 ticks later.
- Pixel (639, 479) → text_addr=2399. Then x=640 → rgb=000 even with font_data=8'hFF.
- Toggle hsync at tick k → hsync_out toggles exactly at tick k+3 (6 clk); same check for vsync.
- cursor_en=1, cursor (5,2), BLINK_FRAMES=2 → after 2 vsync rises, glyph rows 14–15 of cell (5,2) show fg colour with blank font. After 2 more vsync rises → bg colour.
- Assert reset mid-line at x=300 → all outputs 0 on the same edge; blink phase cleared; correct rendering resumes after release.
